ocp_slave_mem_ctrl: RTL and testbench
=====================================

Name: ocp_slave_mem_ctrl

Overview:
OCP slave endpoint that consumes commands from the OCP master bridge and services them from a local word-addressed memory array. It accepts one command at a time and performs single-word reads and writes with a programmable read latency. It returns DVA or ERR responses and holds each response until the master accepts it. Busy and error status are exported for the local controller.

Parameters:
DATA_WIDTH, 32, width of m_data, s_data and each memory word
ADDR_WIDTH, 5, width of m_addr
MEM_DEPTH, 24, number of implemented words; legal range 1..2**ADDR_WIDTH
RD_LATENCY, 2, cycles from the s_cmd_accept cycle to the first read-response cycle; legal range 1..8

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  when low, the FSM, counters, memory and all outputs hold their values
s_ocp  ocp_if.slave  -  inputs m_cmd[2:0], m_addr[ADDR_WIDTH-1:0], m_data[DATA_WIDTH-1:0], m_resp_accept; outputs s_cmd_accept, s_resp[1:0], s_data[DATA_WIDTH-1:0]
busy  output  1  high whenever the state is not IDLE
err_count  output  8  count of ERR responses issued; saturates at 255
parity_inject  input  1  test hook; flips the stored parity bit on the next write (used only with the optional feature)
parity_err  output  1  sticky parity-error flag

Behaviour:
- Encodings:
  - m_cmd: 000 IDLE, 001 WR, 010 RD; every other value is unsupported.
  - s_resp: 00 NULL, 01 DVA, 11 ERR.
- Reset (asynchronous):
  - state=IDLE; s_cmd_accept=0; s_resp=00; s_data=0.
  - busy=0; err_count=0; parity_err=0; latency counter=0.
  - All MEM_DEPTH words cleared to 0.
- All transitions below require enable=1. With enable=0, everything freezes, including a pending response and the latency count.
- IDLE:
  - Trigger: m_cmd!=000.
  - Registered on that edge: m_cmd, m_addr, m_data.
  - Error check: err_pending=1 if m_addr>=MEM_DEPTH or m_cmd is unsupported.
  - Outputs: s_cmd_accept<=1; state<=ACCEPT.
- ACCEPT (exactly one cycle with s_cmd_accept=1). At the edge leaving it, s_cmd_accept<=0, then:
  - err_pending: s_resp<=11; s_data<=0; err_count+1 (saturating); state<=RESP. Memory is not modified.
  - WR: mem[addr]<=data; s_resp<=01; s_data<=0; state<=RESP.
  - RD with RD_LATENCY=1: s_data<=mem[addr]; s_resp<=01; state<=RESP.
  - RD with RD_LATENCY>1: counter<=RD_LATENCY-1; state<=EXEC.
- EXEC:
  - Counter decrements each enabled cycle.
  - When counter==1: s_data<=mem[addr]; s_resp<=01; state<=RESP.
- RESP:
  - s_resp and s_data stay stable until an edge where m_resp_accept=1.
  - On that edge: s_resp<=00; s_data<=0; state<=IDLE.
  - m_cmd is ignored while in RESP.
- Timing:
  - Write and error responses appear in the cycle after the accept cycle.
  - Read responses appear RD_LATENCY cycles after the accept cycle.
  - Minimum gap between successive accepts is 3 cycles (IDLE→ACCEPT→RESP→IDLE).
- m_cmd changing after the IDLE capture edge has no effect on the command in flight.
- An asynchronous reset in any state aborts the operation immediately; no response is issued. A write is lost unless the ACCEPT exit edge has already occurred.

Optional Feature:
Macro: OCP_MEM_PARITY_EN
- Enabled:
  - Each word stores an even-parity bit, written as ^m_data XOR parity_inject.
  - A read checks the stored bit. On mismatch the response is ERR instead of DVA, s_data still carries the stored word, parity_err is set (sticky until reset), and err_count increments.
- Disabled:
  - No parity storage; parity_inject is ignored; parity_err is tied to 0.

Test Plan:
1. WR 0xDEADBEEF to addr 5, then RD addr 5 (RD_LATENCY=2) -> both responses DVA; read s_data=0xDEADBEEF; s_resp rises exactly 2 cycles after the read's accept cycle.
2. After reset, RD addr 3 -> DVA, s_data=0x00000000; busy=1 from the ACCEPT cycle until the cycle after the accepting edge.
3. WR to addr 30 (MEM_DEPTH=24), then m_cmd=011 -> both accepted, both ERR, err_count=2; a read of every address is unchanged.
4. Hold m_resp_accept=0 for 5 cycles during a DVA response -> s_resp=01 and s_data stable throughout; raise it -> s_resp=00 next cycle, state IDLE.
5. Drop enable for 3 cycles in EXEC -> read response delayed by exactly 3 cycles. Assert reset during RESP -> all outputs 0 asynchronously; the next command is serviced normally.
6. With OCP_MEM_PARITY_EN: WR 0x1 to addr 2 with parity_inject=1, then RD addr 2 -> ERR, s_data=0x1, parity_err=1, err_count=1. Without the macro, the same sequence -> DVA, parity_err=0.

Source files
------------

// File: rtl/ocp_slave_mem_ctrl.sv
// OCP slave endpoint servicing single-word reads/writes from a local word array.
// Optional per-word even parity is compiled in with `define OCP_MEM_PARITY_EN.
module ocp_slave_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_DEPTH  = 24,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            m_cmd,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_resp_accept,
  output logic                  s_cmd_accept,
  output logic [1:0]            s_resp,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic                  busy,
  output logic [7:0]            err_count,
  input  logic                  parity_inject,
  output logic                  parity_err
);

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCEPT, ST_EXEC, ST_RESP} state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              cmd_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    err_pending_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    do_capture, do_write, load_resp, load_cnt, dec_cnt, clear_resp;
  logic                    addr_bad, cmd_bad, is_read, par_bad, resp_err;
  logic [MEM_DEPTH-1:0]    word_hit;
  logic [DATA_WIDTH-1:0]   rd_word, resp_data;

  assign busy     = (state_reg != ST_IDLE);
  assign addr_bad = ({1'b0, m_addr} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
  assign cmd_bad  = (m_cmd != CMD_WR) && (m_cmd != CMD_RD);
  assign is_read  = (cmd_reg == CMD_RD) && !err_pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_hit
      assign word_hit[gi] = (addr_reg == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (word_hit[i]) rd_word = mem[i];
    end
  end

`ifdef OCP_MEM_PARITY_EN
  logic inject_reg;
  logic par_mem [MEM_DEPTH];
  logic rd_par;

  always_comb begin
    rd_par = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (word_hit[i]) rd_par = par_mem[i];
    end
  end

  assign par_bad = (^rd_word) != rd_par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inject_reg <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) par_mem[i] <= 1'b0;
    end else begin
      if (do_capture) inject_reg <= parity_inject;
      if (do_write) begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
          if (word_hit[i]) par_mem[i] <= (^data_reg) ^ inject_reg;
        end
      end
    end
  end
`else
  logic unused_parity_inject;
  assign unused_parity_inject = parity_inject;
  assign par_bad = 1'b0;
`endif

  assign resp_err  = err_pending_reg || (is_read && par_bad);
  // A parity-failed read still returns the stored word; only true errors and writes return zero.
  assign resp_data = is_read ? rd_word : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    do_capture = 1'b0;
    do_write   = 1'b0;
    load_resp  = 1'b0;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    clear_resp = 1'b0;
    if (enable) begin
      case (state_reg)
        ST_IDLE: begin
          if (m_cmd != CMD_IDLE) begin
            do_capture = 1'b1;
            state_next = ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (err_pending_reg || cmd_reg == CMD_WR || RD_LATENCY == 1) begin
            do_write   = !err_pending_reg && (cmd_reg == CMD_WR);
            load_resp  = 1'b1;
            state_next = ST_RESP;
          end else begin
            load_cnt   = 1'b1;
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          dec_cnt = 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            load_resp  = 1'b1;
            state_next = ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_resp_accept) begin
            clear_resp = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cmd_accept    <= 1'b0;
      s_resp          <= RESP_NULL;
      s_data          <= '0;
      err_count       <= '0;
      parity_err      <= 1'b0;
      cnt_reg         <= '0;
      cmd_reg         <= CMD_IDLE;
      addr_reg        <= '0;
      data_reg        <= '0;
      err_pending_reg <= 1'b0;
    end else if (enable) begin
      s_cmd_accept <= do_capture;
      if (do_capture) begin
        cmd_reg         <= m_cmd;
        addr_reg        <= m_addr;
        data_reg        <= m_data;
        err_pending_reg <= addr_bad || cmd_bad;
      end
      if (load_cnt)     cnt_reg <= CNT_W'(RD_LATENCY - 1);
      else if (dec_cnt) cnt_reg <= cnt_reg - CNT_W'(1);
      if (load_resp) begin
        s_resp <= resp_err ? RESP_ERR : RESP_DVA;
        s_data <= resp_data;
        if (resp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (is_read && par_bad) parity_err <= 1'b1;
      end else if (clear_resp) begin
        s_resp <= RESP_NULL;
        s_data <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        if (word_hit[i]) mem[i] <= data_reg;
      end
    end
  end

endmodule

// File: tb/tb_ocp_slave_mem_ctrl.sv
// Directed bench for ocp_slave_mem_ctrl: one line per transaction, checks via check_eq.
module tb_ocp_slave_mem_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 24;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset, enable, m_resp_accept, parity_inject;
  logic [2:0]    m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          s_cmd_accept, busy, parity_err;
  logic [1:0]    s_resp;
  logic [DW-1:0] s_data;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_mem [DEPTH];

  ocp_slave_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_data(m_data), .m_resp_accept(m_resp_accept),
    .s_cmd_accept(s_cmd_accept), .s_resp(s_resp), .s_data(s_data),
    .busy(busy), .err_count(err_count), .parity_inject(parity_inject), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m_cmd = cmd; m_addr = addr; m_data = data;
    tick();
    check_eq("accept", {31'd0, s_cmd_accept}, 32'd1);
    check_eq("busy_accept", {31'd0, busy}, 32'd1);
    m_cmd = 3'b000; m_addr = 5'd9; m_data = 32'hFFFF_FFFF;
  endtask

  task automatic wait_resp(inout int lat);
    do begin
      tick();
      lat++;
    end while (s_resp == 2'b00 && lat < 20);
  endtask

  task automatic release_resp;
    m_resp_accept = 1'b1;
    tick();
    m_resp_accept = 1'b0;
    check_eq("resp_cleared", {30'd0, s_resp}, 32'd0);
    check_eq("data_cleared", s_data, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic xact(input string tag, input logic [2:0] cmd, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [1:0] exp_resp,
                      input logic [DW-1:0] exp_data, input int exp_lat);
    int lat = 0;
    issue(cmd, addr, data);
    wait_resp(lat);
    $display("xact %s cmd=%0d addr=%0d resp=%b data=0x%08h lat=%0d", tag, cmd, addr, s_resp, s_data, lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_resp"}, {30'd0, s_resp}, {30'd0, exp_resp});
    check_eq({tag, "_data"}, s_data, exp_data);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    release_resp();
  endtask

  initial begin
    int lat;
    reset = 1'b1; enable = 1'b1; m_resp_accept = 1'b0; parity_inject = 1'b0;
    m_cmd = 3'b000; m_addr = '0; m_data = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    tick();
    check_eq("rst_accept", {31'd0, s_cmd_accept}, 32'd0);
    check_eq("rst_resp", {30'd0, s_resp}, 32'd0);
    check_eq("rst_data", s_data, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_errcnt", {24'd0, err_count}, 32'd0);
    check_eq("rst_parerr", {31'd0, parity_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Read of cleared memory, then write/read-back
    xact("rd3_cleared", 3'b010, 5'd3, 32'h0, 2'b01, 32'h0, LAT);
    xact("wr5", 3'b001, 5'd5, 32'hDEAD_BEEF, 2'b01, 32'h0, 1);
    model_mem[5] = 32'hDEAD_BEEF;
    xact("rd5", 3'b010, 5'd5, 32'h0, 2'b01, 32'hDEAD_BEEF, LAT);
    xact("wr23", 3'b001, 5'd23, 32'hA5A5_0123, 2'b01, 32'h0, 1);
    model_mem[23] = 32'hA5A5_0123;
    xact("wr0", 3'b001, 5'd0, 32'h1234_5678, 2'b01, 32'h0, 1);
    model_mem[0] = 32'h1234_5678;

    // Error responses: out of range address and unsupported command
    xact("wr30_err", 3'b001, 5'd30, 32'h5555_AAAA, 2'b11, 32'h0, 1);
    xact("cmd3_err", 3'b011, 5'd1, 32'h1111_1111, 2'b11, 32'h0, 1);
    check_eq("errcnt_2", {24'd0, err_count}, 32'd2);
    xact("wr24_err", 3'b001, 5'd24, 32'h2424_2424, 2'b11, 32'h0, 1);
    check_eq("errcnt_3", {24'd0, err_count}, 32'd3);
    for (int i = 0; i < DEPTH; i++) begin
      xact($sformatf("sweep%0d", i), 3'b010, AW'(i), 32'h0, 2'b01, model_mem[i], LAT);
    end

    // Response held while the master withholds acceptance
    lat = 0;
    issue(3'b010, 5'd23, 32'h0);
    wait_resp(lat);
    $display("xact hold23 resp=%b data=0x%08h lat=%0d", s_resp, s_data, lat);
    check_eq("hold_lat", lat, LAT);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_resp", {30'd0, s_resp}, 32'd1);
      check_eq("hold_data", s_data, 32'hA5A5_0123);
      tick();
    end
    check_eq("hold_resp_end", {30'd0, s_resp}, 32'd1);
    release_resp();

    // Enable dropped for three cycles while in EXEC
    lat = 0;
    issue(3'b010, 5'd5, 32'h0);
    tick(); lat++;
    check_eq("en_exec_resp", {30'd0, s_resp}, 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); lat++;
      check_eq("en_frozen_resp", {30'd0, s_resp}, 32'd0);
    end
    enable = 1'b1;
    wait_resp(lat);
    $display("xact en_stall resp=%b data=0x%08h lat=%0d", s_resp, s_data, lat);
    check_eq("en_lat", lat, LAT + 3);
    check_eq("en_data", s_data, 32'hDEAD_BEEF);
    release_resp();

    // Asynchronous reset while a write response is pending
    lat = 0;
    issue(3'b001, 5'd7, 32'h7777_7777);
    wait_resp(lat);
    check_eq("pre_rst_resp", {30'd0, s_resp}, 32'd1);
    #2 reset = 1'b1;
    #1;
    $display("xact async_reset resp=%b data=0x%08h busy=%0d", s_resp, s_data, busy);
    check_eq("arst_resp", {30'd0, s_resp}, 32'd0);
    check_eq("arst_data", s_data, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_errcnt", {24'd0, err_count}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    tick();
    xact("rd7_after_rst", 3'b010, 5'd7, 32'h0, 2'b01, 32'h0, LAT);
    xact("rd5_after_rst", 3'b010, 5'd5, 32'h0, 2'b01, 32'h0, LAT);

    // Parity injection on a write, then read it back
    parity_inject = 1'b1;
    xact("wr2_inject", 3'b001, 5'd2, 32'h0000_0001, 2'b01, 32'h0, 1);
    parity_inject = 1'b0;
`ifdef OCP_MEM_PARITY_EN
    xact("rd2_parity", 3'b010, 5'd2, 32'h0, 2'b11, 32'h0000_0001, LAT);
    check_eq("parity_err", {31'd0, parity_err}, 32'd1);
    check_eq("parity_errcnt", {24'd0, err_count}, 32'd1);
`else
    xact("rd2_parity", 3'b010, 5'd2, 32'h0, 2'b01, 32'h0000_0001, LAT);
    check_eq("parity_err", {31'd0, parity_err}, 32'd0);
    check_eq("parity_errcnt", {24'd0, err_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
